// File: rtl/decode_sequencer.sv
// Byte-stream decoder sequencer: reads each byte from a synchronous source memory,
// passes it through an external rotate-right shifter and writes the result back out.
module decode_sequencer #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] length,
  input  logic [2:0]        key,
  input  logic              rolling,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        rd_data,
  output logic [7:0]        sh_in,
  output logic [3:0]        sh_rot,
  input  logic [7:0]        sh_out,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              busy,
  output logic              done,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_SHIFT = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [7:0]        data_q, data_d;
  logic [ADDR_W-1:0] len_q, len_d;
  logic [2:0]        key_q, key_d;
  logic              roll_q, roll_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [ADDR_W:0]   idx_nxt;
  logic [2:0]        rot;

  // One extra bit so the last-byte test cannot wrap at the maximum length.
  assign idx_nxt = {1'b0, idx_q} + (ADDR_W+1)'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      data_q    <= '0;
      len_q     <= '0;
      key_q     <= '0;
      roll_q    <= 1'b0;
      rd_addr_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      data_q    <= data_d;
      len_q     <= len_d;
      key_q     <= key_d;
      roll_q    <= roll_d;
      rd_addr_q <= rd_addr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    data_d    = data_q;
    len_d     = len_q;
    key_d     = key_q;
    roll_d    = roll_q;
    rd_addr_d = rd_addr_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          len_d   = length;
          key_d   = key;
          roll_d  = rolling;
          idx_d   = '0;
          state_d = (length != '0) ? S_READ : S_DONE;
        end
      end
      S_READ: begin
        rd_addr_d = idx_q;
        state_d   = S_SHIFT;
      end
      S_SHIFT: begin
        data_d  = rd_data;
        state_d = S_WRITE;
      end
      S_WRITE: begin
        idx_d   = idx_nxt[ADDR_W-1:0];
        state_d = (idx_nxt < {1'b0, len_q}) ? S_READ : S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Rolling mode adds the low index bits to the key; the 3-bit sum wraps 7 -> 0.
  assign rot       = roll_q ? (key_q + idx_q[2:0]) : key_q;
  assign sh_rot    = {1'b0, rot};
  assign sh_in     = data_q;
  assign rd_addr   = (state_q == S_READ) ? idx_q : rd_addr_q;
  assign wr_en     = (state_q == S_WRITE);
  assign wr_addr   = idx_q;
  assign wr_data   = sh_out;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_decode_sequencer.sv
// Directed bench for decode_sequencer: source memory and rotate-right shifter models,
// a negedge monitor logging writes/done pulses, and one task per scenario.
module tb_decode_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] length;
  logic [2:0] key;
  logic       rolling;
  logic [7:0] rd_addr;
  logic [7:0] rd_data;
  logic [7:0] sh_in;
  logic [3:0] sh_rot;
  logic [7:0] sh_out;
  logic       wr_en;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy;
  logic       done;
  logic [2:0] dbg_state;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [7:0] mem [0:255];
  int         mw_cyc  [$];
  logic [7:0] mw_addr [$];
  logic [7:0] mw_data [$];
  logic [3:0] mw_rot  [$];
  int         md_cyc  [$];
  int         busy_cnt;
  logic [7:0] exp_q   [$];

  decode_sequencer #(.ADDR_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .length(length), .key(key), .rolling(rolling),
    .rd_addr(rd_addr), .rd_data(rd_data), .sh_in(sh_in), .sh_rot(sh_rot), .sh_out(sh_out),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .done(done),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset, environment models ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] rotr8(input logic [7:0] v, input int r);
    logic [15:0] w;
    w = {v, v} >> r;
    return w[7:0];
  endfunction

  always @(posedge clk) rd_data <= mem[rd_addr];
  assign sh_out = rotr8(sh_in, int'(sh_rot[2:0]));

  always @(negedge clk) begin
    if (wr_en) begin
      mw_cyc.push_back(cyc);
      mw_addr.push_back(wr_addr);
      mw_data.push_back(wr_data);
      mw_rot.push_back(sh_rot);
    end
    if (done) md_cyc.push_back(cyc);
    if (busy) busy_cnt++;
  end

  // ---------------- driver tasks ----------------
  task automatic clear_mon();
    mw_cyc.delete(); mw_addr.delete(); mw_data.delete(); mw_rot.delete();
    md_cyc.delete(); exp_q.delete();
    busy_cnt = 0;
  endtask

  task automatic pulse_start(input logic [7:0] len, input logic [2:0] k, input logic roll,
                             output int t);
    @(negedge clk);
    clear_mon();
    length = len; key = k; rolling = roll; start = 1'b1;
    t = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int n = 0;
    while (md_cyc.size() == 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    n_cmp++;
    if (md_cyc.size() == 0) begin
      n_err++;
      $display("FAIL %s timeout: no done within %0d cycles", name, budget);
    end
    repeat (3) @(negedge clk);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1; start = 1'b0; length = '0; key = '0; rolling = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({wr_en, done, busy} !== 3'b000) begin
      n_err++; $display("FAIL reset_ctl got %b want 000", {wr_en, done, busy});
    end
    n_cmp++;
    if ({rd_addr, wr_addr, sh_in} !== 24'h0) begin
      n_err++; $display("FAIL reset_bus got %h want 000000", {rd_addr, wr_addr, sh_in});
    end
    n_cmp++;
    if (sh_rot !== 4'h0) begin
      n_err++; $display("FAIL reset_rot got %h want 0", sh_rot);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single();
    int t;
    mem[0] = 8'hB4;
    pulse_start(8'd1, 3'd3, 1'b0, t);
    wait_done(20, "single");
    n_cmp++;
    if (mw_data.size() !== 1) begin
      n_err++; $display("FAIL single_count got %0d want 1", mw_data.size());
    end else begin
      n_cmp++;
      if ({mw_addr[0], mw_data[0]} !== 16'h0096) begin
        n_err++; $display("FAIL single_write got %h/%h want 00/96", mw_addr[0], mw_data[0]);
      end
      n_cmp++;
      if (mw_cyc[0] !== t + 3) begin
        n_err++; $display("FAIL single_wcyc got %0d want %0d", mw_cyc[0], t + 3);
      end
    end
    n_cmp++;
    if (md_cyc.size() !== 1 || md_cyc[0] !== t + 4) begin
      n_err++; $display("FAIL single_done got %0d pulses first@%0d want 1@%0d",
                        md_cyc.size(), (md_cyc.size() > 0) ? md_cyc[0] : -1, t + 4);
    end
  endtask

  task automatic test_rolling();
    int t;
    logic [7:0] ed [2];
    logic [3:0] er [2];
    ed[0] = 8'h03; ed[1] = 8'h81;
    er[0] = 4'b0111; er[1] = 4'b0000;
    mem[0] = 8'h81; mem[1] = 8'h81;
    pulse_start(8'd2, 3'd7, 1'b1, t);
    wait_done(20, "rolling");
    n_cmp++;
    if (mw_data.size() !== 2) begin
      n_err++; $display("FAIL rolling_count got %0d want 2", mw_data.size());
    end else begin
      for (int k = 0; k < 2; k++) begin
        n_cmp++;
        if (mw_addr[k] !== 8'(k) || mw_data[k] !== ed[k] || mw_rot[k] !== er[k]
            || mw_cyc[k] !== t + 3 * (k + 1)) begin
          n_err++;
          $display("FAIL rolling_w%0d got a=%h d=%h rot=%b c=%0d want a=%h d=%h rot=%b c=%0d",
                   k, mw_addr[k], mw_data[k], mw_rot[k], mw_cyc[k], k, ed[k], er[k], t + 3 * (k + 1));
        end
      end
    end
    n_cmp++;
    if (md_cyc.size() !== 1 || md_cyc[0] !== t + 7) begin
      n_err++; $display("FAIL rolling_done got %0d pulses want 1@%0d", md_cyc.size(), t + 7);
    end
  endtask

  task automatic test_zero_len();
    int t;
    pulse_start(8'd0, 3'd5, 1'b1, t);
    wait_done(10, "zero");
    n_cmp++;
    if (mw_data.size() !== 0) begin
      n_err++; $display("FAIL zero_writes got %0d want 0", mw_data.size());
    end
    n_cmp++;
    if (md_cyc.size() !== 1 || md_cyc[0] !== t + 1) begin
      n_err++; $display("FAIL zero_done got %0d pulses first@%0d want 1@%0d",
                        md_cyc.size(), (md_cyc.size() > 0) ? md_cyc[0] : -1, t + 1);
    end
    n_cmp++;
    if (busy_cnt !== 1) begin
      n_err++; $display("FAIL zero_busy got %0d cycles want 1", busy_cnt);
    end
  endtask

  task automatic test_busy_start();
    int t;
    logic [7:0] src [4];
    logic [7:0] ed [4];
    src[0] = 8'h01; src[1] = 8'hF0; src[2] = 8'h3C; src[3] = 8'h80;
    ed[0]  = 8'h40; ed[1]  = 8'h3C; ed[2]  = 8'h0F; ed[3]  = 8'h20;
    for (int k = 0; k < 4; k++) mem[k] = src[k];
    pulse_start(8'd4, 3'd2, 1'b0, t);
    while (cyc < t + 5) @(negedge clk);
    start = 1'b1; length = 8'd1; key = 3'd5; rolling = 1'b1;
    @(negedge clk);
    start = 1'b0; length = 8'd9; key = 3'd6;
    wait_done(30, "busy");
    repeat (20) @(negedge clk);
    n_cmp++;
    if (mw_data.size() !== 4) begin
      n_err++; $display("FAIL busy_count got %0d want 4", mw_data.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        n_cmp++;
        if (mw_addr[k] !== 8'(k) || mw_data[k] !== ed[k]) begin
          n_err++; $display("FAIL busy_w%0d got %h/%h want %h/%h", k, mw_addr[k], mw_data[k], k, ed[k]);
        end
      end
    end
    n_cmp++;
    if (md_cyc.size() !== 1 || md_cyc[0] !== t + 13) begin
      n_err++; $display("FAIL busy_done got %0d pulses first@%0d want 1@%0d",
                        md_cyc.size(), (md_cyc.size() > 0) ? md_cyc[0] : -1, t + 13);
    end
  endtask

  task automatic test_reset_mid();
    int t;
    logic [7:0] ed [3];
    for (int k = 0; k < 8; k++) mem[k] = 8'(k * 17 + 3);
    pulse_start(8'd8, 3'd1, 1'b0, t);
    while (cyc < t + 7) @(negedge clk);
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({wr_en, busy, done} !== 3'b000) begin
      n_err++; $display("FAIL rstmid_async got %b want 000", {wr_en, busy, done});
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    n_cmp++;
    if (mw_data.size() !== 2 || md_cyc.size() !== 0 || busy !== 1'b0) begin
      n_err++; $display("FAIL rstmid_abort got %0d writes %0d done busy=%b want 2 0 0",
                        mw_data.size(), md_cyc.size(), busy);
    end
    mem[0] = 8'h12; mem[1] = 8'h34; mem[2] = 8'hA5;
    ed[0] = 8'h21; ed[1] = 8'h43; ed[2] = 8'h5A;
    pulse_start(8'd3, 3'd4, 1'b0, t);
    wait_done(20, "rstmid_fresh");
    n_cmp++;
    if (mw_data.size() !== 3) begin
      n_err++; $display("FAIL rstmid_count got %0d want 3", mw_data.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        n_cmp++;
        if (mw_addr[k] !== 8'(k) || mw_data[k] !== ed[k]) begin
          n_err++; $display("FAIL rstmid_w%0d got %h/%h want %h/%h", k, mw_addr[k], mw_data[k], k, ed[k]);
        end
      end
    end
    n_cmp++;
    if (md_cyc.size() !== 1 || md_cyc[0] !== t + 10) begin
      n_err++; $display("FAIL rstmid_done got %0d pulses want 1@%0d", md_cyc.size(), t + 10);
    end
  endtask

  task automatic test_max_len();
    int t;
    int bad = 0;
    for (int k = 0; k < 256; k++) mem[k] = 8'($urandom_range(0, 255));
    pulse_start(8'd255, 3'd1, 1'b0, t);
    for (int k = 0; k < 255; k++) exp_q.push_back(rotr8(mem[k], 1));
    wait_done(800, "max");
    n_cmp++;
    if (mw_data.size() !== 255) begin
      n_err++; $display("FAIL max_count got %0d want 255", mw_data.size());
    end else begin
      for (int k = 0; k < 255; k++) begin
        logic [7:0] e;
        e = exp_q.pop_front();
        n_cmp++;
        if (mw_addr[k] !== 8'(k) || mw_data[k] !== e || mw_cyc[k] !== t + 3 * (k + 1)) begin
          n_err++;
          if (bad < 5)
            $display("FAIL max_w%0d got a=%h d=%h c=%0d want a=%h d=%h c=%0d",
                     k, mw_addr[k], mw_data[k], mw_cyc[k], k, e, t + 3 * (k + 1));
          bad++;
        end
      end
    end
    n_cmp++;
    if (md_cyc.size() !== 1 || md_cyc[0] !== t + 766) begin
      n_err++; $display("FAIL max_done got %0d pulses first@%0d want 1@%0d",
                        md_cyc.size(), (md_cyc.size() > 0) ? md_cyc[0] : -1, t + 766);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    for (int k = 0; k < 256; k++) mem[k] = 8'h00;
    test_reset();
    test_single();
    test_rolling();
    test_zero_len();
    test_busy_start();
    test_reset_mid();
    test_max_len();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
